// File: rtl/dm_responder.sv
// Data-memory responder: byte/half/word load/store, response LATENCY+1 cycles after acceptance.
// Backpressure: req_ready low while BUSY; a new request may be accepted in the RESP cycle.
module dm_responder #(
  parameter int DEPTH_WORDS = 3072,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);
  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, commit;

  logic        l_we, l_sign;
  logic [31:0] l_addr, l_wdata, l_pc;
  logic [1:0]  l_size;

  logic        op_we, op_sign;
  logic [31:0] op_addr, op_wdata, op_pc;
  logic [1:0]  op_size;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [DEPTH_WORDS-1:0] word_vld;
  logic [AW-1:0] widx;
  logic          in_range, err, wr_en;
  logic [31:0]   rd_word, shifted, merged, ld_dat;
  logic [4:0]    lane_shift;

  logic          rsp_vld_q, rsp_err_q, trace_vld_q;
  logic [31:0]   rsp_rdata_q, trace_pc_q, trace_addr_q, trace_data_q;

  assign req_ready = (state != BUSY);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_nxt = RESP;
            commit    = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = 4'(LATENCY - 1);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With zero latency the commit edge is the acceptance edge, so operate on the live request.
  assign op_we    = (LATENCY == 0) ? req_we    : l_we;
  assign op_sign  = (LATENCY == 0) ? req_sign  : l_sign;
  assign op_addr  = (LATENCY == 0) ? req_addr  : l_addr;
  assign op_wdata = (LATENCY == 0) ? req_wdata : l_wdata;
  assign op_pc    = (LATENCY == 0) ? req_pc    : l_pc;
  assign op_size  = (LATENCY == 0) ? req_size  : l_size;

  assign widx       = op_addr[AW+1:2];
  assign in_range   = (op_addr < BYTE_LIMIT);
  assign lane_shift = {op_addr[1:0], 3'b000};

  always_comb begin
    err = 1'b0;
    case (op_size)
      2'b01:   err = op_addr[0];
      2'b10:   err = |op_addr[1:0];
      2'b11:   err = 1'b1;
      default: err = 1'b0;
    endcase
    if (!in_range) err = 1'b1;
  end

  // Words never written since reset read as zero, so reset need not touch the array itself.
  assign rd_word = (in_range && word_vld[widx]) ? mem[widx] : 32'd0;
  assign shifted = rd_word >> lane_shift;

  always_comb begin
    merged = rd_word;
    case (op_size)
      2'b00:   merged[{op_addr[1:0], 3'b000} +: 8] = op_wdata[7:0];
      2'b01:   merged[{op_addr[1], 4'b0000} +: 16] = op_wdata[15:0];
      default: merged = op_wdata;
    endcase
  end

  always_comb begin
    case (op_size)
      2'b00:   ld_dat = {{24{op_sign & shifted[7]}}, shifted[7:0]};
      2'b01:   ld_dat = {{16{op_sign & shifted[15]}}, shifted[15:0]};
      default: ld_dat = rd_word;
    endcase
  end

  assign wr_en = reset && commit && op_we && !err;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      word_vld     <= '0;
      rsp_vld_q    <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 32'd0;
      trace_vld_q  <= 1'b0;
      trace_pc_q   <= 32'd0;
      trace_addr_q <= 32'd0;
      trace_data_q <= 32'd0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      rsp_vld_q    <= commit;
      rsp_err_q    <= commit && err;
      rsp_rdata_q  <= (commit && !err && !op_we) ? ld_dat : 32'd0;
      trace_vld_q  <= commit && !err && op_we;
      trace_pc_q   <= (commit && !err && op_we) ? op_pc : 32'd0;
      trace_addr_q <= (commit && !err && op_we) ? {op_addr[31:2], 2'b00} : 32'd0;
      trace_data_q <= (commit && !err && op_we) ? merged : 32'd0;
      if (wr_en) word_vld[widx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      l_we    <= req_we;
      l_sign  <= req_sign;
      l_addr  <= req_addr;
      l_wdata <= req_wdata;
      l_pc    <= req_pc;
      l_size  <= req_size;
    end
    if (wr_en) mem[widx] <= merged;
  end

  assign rsp_valid   = rsp_vld_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign trace_valid = trace_vld_q;
  assign trace_pc    = trace_pc_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;
endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: three instances (LATENCY 2, 0, 3) driven by directed and random requests.
module tb_dm_responder;
  localparam int NI    = 3;
  localparam int DEPTH = 3072;

  typedef struct {
    int          due;
    bit          we;
    logic        err;
    logic [31:0] rdata;
    logic        tv;
    logic [31:0] tpc, taddr, tdata;
    bit          hk;
    logic [31:0] kv;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset [NI];
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_we [NI];
  logic [31:0] req_addr [NI];
  logic [1:0]  req_size [NI];
  logic        req_sign [NI];
  logic [31:0] req_wdata [NI];
  logic [31:0] req_pc [NI];
  logic        rsp_valid [NI];
  logic [31:0] rsp_rdata [NI];
  logic        rsp_err [NI];
  logic        trace_valid [NI];
  logic [31:0] trace_pc [NI];
  logic [31:0] trace_addr [NI];
  logic [31:0] trace_data [NI];

  int          lat_of [NI] = '{2, 0, 3};
  exp_t        exp_q [NI][$];
  logic [31:0] mmem [NI][DEPTH];
  bit          active [NI];
  bit          rst_hold [NI];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 0 : 3);
    dm_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(L)) dut (
      .clk(clk), .reset(reset[g]),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
      .req_addr(req_addr[g]), .req_size(req_size[g]), .req_sign(req_sign[g]),
      .req_wdata(req_wdata[g]), .req_pc(req_pc[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g]),
      .trace_valid(trace_valid[g]), .trace_pc(trace_pc[g]),
      .trace_addr(trace_addr[g]), .trace_data(trace_data[g])
    );
  end

  function automatic void chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %h required %h (cycle %0d)", g, nm, act, req, cyc);
    end
  endfunction

  // Reference: applies each request to a byte-lane view of memory in acceptance order.
  function automatic exp_t model(input int g, input bit we, input logic [31:0] a, input logic [1:0] sz,
                                 input bit sg, input logic [31:0] wd, input logic [31:0] pc);
    exp_t        e;
    int          nb, lane;
    logic [31:0] w;
    logic [63:0] v;
    e = '{default: 0};
    e.we  = we;
    nb    = 1 << sz;
    lane  = int'(a % 4);
    e.err = (sz == 2'd3) || ((a % 32'(nb)) != 0) || (a >= 32'(DEPTH * 4));
    if (!e.err) begin
      w = mmem[g][a / 4];
      if (we) begin
        for (int i = 0; i < nb; i++) w[8 * (lane + i) +: 8] = wd[8 * i +: 8];
        mmem[g][a / 4] = w;
        e.tv    = 1'b1;
        e.tpc   = pc;
        e.taddr = a - 32'(lane);
        e.tdata = w;
      end else begin
        v = {32'd0, w} >> (8 * lane);
        v = v & ((64'd1 << (8 * nb)) - 64'd1);
        if (sg && nb < 4 && v >= (64'd1 << (8 * nb - 1)))
          v = v + (64'd1 << 32) - (64'd1 << (8 * nb));
        e.rdata = v[31:0];
      end
    end
    return e;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_mon
    always @(negedge clk) begin
      exp_t        e;
      logic        exp_rdy;
      if (active[g] && !rst_hold[g]) begin
        exp_rdy = 1'b1;
        if (exp_q[g].size() > 0 && cyc < exp_q[g][0].due) exp_rdy = 1'b0;
        chk(g, "req_ready", 32'(req_ready[g]), 32'(exp_rdy));
        if (rsp_valid[g]) begin
          if (exp_q[g].size() == 0) begin
            chk(g, "rsp_valid_unexpected", 32'(rsp_valid[g]), 32'd0);
          end else begin
            e = exp_q[g].pop_front();
            chk(g, "rsp_cycle", 32'(cyc), 32'(e.due));
            chk(g, "rsp_err", 32'(rsp_err[g]), 32'(e.err));
            chk(g, "rsp_rdata", rsp_rdata[g], e.rdata);
            chk(g, "trace_valid", 32'(trace_valid[g]), 32'(e.tv));
            chk(g, "trace_pc", trace_pc[g], e.tpc);
            chk(g, "trace_addr", trace_addr[g], e.taddr);
            chk(g, "trace_data", trace_data[g], e.tdata);
            if (e.hk) chk(g, "known_value", e.we ? trace_data[g] : rsp_rdata[g], e.kv);
          end
        end else begin
          chk(g, "idle_outputs", rsp_rdata[g] | trace_pc[g] | trace_addr[g] | trace_data[g]
                                 | {30'd0, rsp_err[g], trace_valid[g]}, 32'd0);
          if (exp_q[g].size() > 0 && cyc >= exp_q[g][0].due) begin
            e = exp_q[g].pop_front();
            chk(g, "rsp_missing", 32'(rsp_valid[g]), 32'd1);
          end
        end
      end
    end
  end

  // All driver tasks start and end at 1 time unit after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int g);
    rst_hold[g]  = 1'b1;
    reset[g]     = 1'b0;
    req_valid[g] = 1'b0;
    exp_q[g].delete();
    for (int i = 0; i < DEPTH; i++) mmem[g][i] = 32'd0;
    step(1);
    reset[g]    = 1'b1;
    rst_hold[g] = 1'b0;
    active[g]   = 1'b1;
  endtask

  task automatic issue(input int g, input bit we, input logic [31:0] a, input logic [1:0] sz,
                       input bit sg, input logic [31:0] wd, input logic [31:0] pc,
                       input bit hk, input logic [31:0] kv);
    exp_t e;
    int   acc;
    int   waited;
    req_we[g]    = we;
    req_addr[g]  = a;
    req_size[g]  = sz;
    req_sign[g]  = sg;
    req_wdata[g] = wd;
    req_pc[g]    = pc;
    req_valid[g] = 1'b1;
    waited = 0;
    while (!req_ready[g] && waited < 50) begin
      step(1);
      waited++;
    end
    if (!req_ready[g]) begin
      chk(g, "ready_timeout", 32'(req_ready[g]), 32'd1);
      req_valid[g] = 1'b0;
      return;
    end
    acc = cyc;
    step(1);
    req_valid[g] = 1'b0;
    e     = model(g, we, a, sz, sg, wd, pc);
    e.due = acc + 1 + lat_of[g];
    e.hk  = hk;
    e.kv  = kv;
    exp_q[g].push_back(e);
  endtask

  task automatic drain(input int g);
    int n;
    n = 0;
    while (exp_q[g].size() > 0 && n < 100) begin
      step(1);
      n++;
    end
    if (exp_q[g].size() > 0) chk(g, "drain_timeout", 32'(exp_q[g].size()), 32'd0);
  endtask

  task automatic run_inst(input int g);
    logic [31:0] a;
    logic [1:0]  sz;
    int          r;
    step(1);
    do_reset(g);
    issue(g, 1'b0, 32'(DEPTH * 4 - 4), 2'd2, 1'b0, 32'd0, 32'h0, 1'b1, 32'd0);
    drain(g);
    if (g == 0) begin
      issue(g, 1'b1, 32'h10, 2'd2, 1'b0, 32'h12345678, 32'h400, 1'b1, 32'h12345678);
      drain(g);
      issue(g, 1'b0, 32'h13, 2'd0, 1'b1, 32'd0, 32'h404, 1'b1, 32'h00000012);
      issue(g, 1'b1, 32'h11, 2'd0, 1'b0, 32'h000000AB, 32'h408, 1'b1, 32'h1234AB78);
      issue(g, 1'b0, 32'h11, 2'd0, 1'b1, 32'd0, 32'h40C, 1'b1, 32'hFFFFFFAB);
      issue(g, 1'b0, 32'h11, 2'd0, 1'b0, 32'd0, 32'h410, 1'b1, 32'h000000AB);
      issue(g, 1'b0, 32'h12, 2'd1, 1'b1, 32'd0, 32'h414, 1'b1, 32'h00001234);
      issue(g, 1'b0, 32'h3, 2'd1, 1'b1, 32'd0, 32'h418, 1'b1, 32'd0);
      issue(g, 1'b0, 32'h2, 2'd2, 1'b0, 32'd0, 32'h41C, 1'b1, 32'd0);
      issue(g, 1'b0, 32'h3000, 2'd2, 1'b0, 32'd0, 32'h420, 1'b1, 32'd0);
      issue(g, 1'b0, 32'h10, 2'd3, 1'b0, 32'd0, 32'h424, 1'b1, 32'd0);
      issue(g, 1'b1, 32'h11, 2'd1, 1'b0, 32'hFFFF, 32'h428, 1'b1, 32'd0);
      issue(g, 1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 32'h42C, 1'b1, 32'h1234AB78);
      drain(g);
    end else if (g == 1) begin
      issue(g, 1'b1, 32'h20, 2'd2, 1'b0, 32'h5, 32'h500, 1'b1, 32'h5);
      issue(g, 1'b0, 32'h20, 2'd2, 1'b0, 32'd0, 32'h504, 1'b1, 32'h5);
      drain(g);
    end else begin
      issue(g, 1'b1, 32'h40, 2'd2, 1'b0, 32'hFF, 32'h600, 1'b0, 32'd0);
      step(1);
      do_reset(g);
      step(4);
      issue(g, 1'b0, 32'h40, 2'd2, 1'b0, 32'd0, 32'h604, 1'b1, 32'd0);
      drain(g);
    end
    repeat (150) begin
      r  = $urandom_range(0, 9);
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if (r < 8)       a = 32'($urandom_range(0, 63));
      else if (r == 8) a = 32'(DEPTH * 4 - 8) + 32'($urandom_range(0, 15));
      else             a = $urandom;
      if ($urandom_range(0, 1) == 1 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      issue(g, 1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom, $urandom,
            1'b0, 32'd0);
      r = $urandom_range(0, 3);
      if (r < 3) step(r);
    end
    drain(g);
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      reset[g]     = 1'b0;
      req_valid[g] = 1'b0;
      req_we[g]    = 1'b0;
      req_addr[g]  = 32'd0;
      req_size[g]  = 2'd0;
      req_sign[g]  = 1'b0;
      req_wdata[g] = 32'd0;
      req_pc[g]    = 32'd0;
      active[g]    = 1'b0;
      rst_hold[g]  = 1'b0;
    end
    fork
      run_inst(0);
      run_inst(1);
      run_inst(2);
    join
    step(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
